// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin sharing of one single-transaction SDRAM controller between a fetch port and a data port
module sdram_arbiter #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 64
) (
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic              ip0_req,
  input  logic [ADDR_W-1:0] ip0_address,
  output logic              op0_ack,
  output logic [DATA_W-1:0] op0_data,
  input  logic              ip1_req,
  input  logic              ip1_we,
  input  logic [ADDR_W-1:0] ip1_address,
  input  logic [DATA_W-1:0] ip1_wdata,
  output logic              op1_ack,
  output logic [DATA_W-1:0] op1_rdata,
  output logic              owrite_req,
  output logic [ADDR_W-1:0] owrite_address,
  output logic [DATA_W-1:0] owrite_data,
  input  logic              iwrite_ack,
  output logic              oread_req,
  output logic [ADDR_W-1:0] oread_address,
  input  logic [DATA_W-1:0] iread_data,
  input  logic              iread_ack,
  output logic              obusy
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic last, gnt, pick;
  logic [ADDR_W-1:0] addr;
  assign pick = (ip0_req & ip1_req) ? ~last : ip1_req;
  assign owrite_address = addr;
  assign oread_address = addr;
  assign obusy = state != IDLE;
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state <= IDLE;
      last <= 1'b1;
      gnt <= 1'b0;
      addr <= '0;
      owrite_data <= '0;
      owrite_req <= 1'b0;
      oread_req <= 1'b0;
      op0_ack <= 1'b0;
      op1_ack <= 1'b0;
      op0_data <= '0;
      op1_rdata <= '0;
    end else begin
      op0_ack <= 1'b0;
      op1_ack <= 1'b0;
      if (state == IDLE && (ip0_req | ip1_req)) begin
        state <= BUSY;
        gnt <= pick;
        last <= pick;
        addr <= pick ? ip1_address : ip0_address;
        owrite_data <= pick ? ip1_wdata : '0;
        owrite_req <= pick & ip1_we;
        oread_req <= ~(pick & ip1_we);
      end else if (state == BUSY && ((owrite_req & iwrite_ack) | (oread_req & iread_ack))) begin
        state <= DONE;
        owrite_req <= 1'b0;
        oread_req <= 1'b0;
        if (oread_req & ~gnt) op0_data <= iread_data;
        if (oread_req & gnt) op1_rdata <= iread_data;
      end else if (state == DONE) begin
        state <= IDLE;
        op0_ack <= ~gnt;
        op1_ack <= gnt;
      end
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed scoreboard bench for sdram_arbiter
module tb_sdram_arbiter;
  logic iclk = 1'b0, ireset_n = 1'b0;
  logic ip0_req = 1'b0, ip1_req = 1'b0, ip1_we = 1'b0;
  logic [21:0] ip0_address = '0, ip1_address = '0;
  logic [63:0] ip1_wdata = '0, iread_data = '0;
  logic iwrite_ack = 1'b0, iread_ack = 1'b0;
  logic op0_ack, op1_ack, owrite_req, oread_req, obusy;
  logic [63:0] op0_data, op1_rdata, owrite_data;
  logic [21:0] owrite_address, oread_address;
  typedef struct packed {logic port; logic [63:0] data;} sb_t;
  sb_t sb_q[$];
  logic [63:0] m0 = '0, m1 = '0;
  int checks = 0, errors = 0;
  sdram_arbiter #(.ADDR_W(22), .DATA_W(64)) dut (
    .iclk(iclk), .ireset_n(ireset_n),
    .ip0_req(ip0_req), .ip0_address(ip0_address), .op0_ack(op0_ack), .op0_data(op0_data),
    .ip1_req(ip1_req), .ip1_we(ip1_we), .ip1_address(ip1_address), .ip1_wdata(ip1_wdata),
    .op1_ack(op1_ack), .op1_rdata(op1_rdata),
    .owrite_req(owrite_req), .owrite_address(owrite_address), .owrite_data(owrite_data),
    .iwrite_ack(iwrite_ack), .oread_req(oread_req), .oread_address(oread_address),
    .iread_data(iread_data), .iread_ack(iread_ack), .obusy(obusy)
  );
  always #5 iclk = ~iclk;
  task automatic tick;
    @(posedge iclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic serve(input bit port, input bit we, input logic [21:0] addr, input logic [63:0] wd,
                       input logic [63:0] rd, input int hold, input bit drop);
    int n = 0;
    sb_t e;
    while (!(owrite_req | oread_req) && n < 20) begin
      tick;
      n++;
    end
    chk("req_seen", {63'd0, owrite_req | oread_req}, 64'd1);
    chk("req_w", {63'd0, owrite_req}, {63'd0, we});
    chk("req_r", {63'd0, oread_req}, {63'd0, !we});
    chk("addr", {42'd0, we ? owrite_address : oread_address}, {42'd0, addr});
    if (we) chk("wdata", owrite_data, wd);
    chk("busy", {63'd0, obusy}, 64'd1);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_w", {63'd0, owrite_req}, {63'd0, we});
      chk("hold_r", {63'd0, oread_req}, {63'd0, !we});
      chk("hold_addr", {42'd0, we ? owrite_address : oread_address}, {42'd0, addr});
      chk("hold_noack", {63'd0, op0_ack | op1_ack}, 64'd0);
    end
    if (we) iwrite_ack = 1'b1;
    else begin
      iread_ack = 1'b1;
      iread_data = rd;
      if (port) m1 = rd;
      else m0 = rd;
    end
    sb_q.push_back({port, port ? m1 : m0});
    tick;
    iwrite_ack = 1'b0;
    iread_ack = 1'b0;
    iread_data = 64'h5555_AAAA_5555_AAAA;
    chk("req_clear", {63'd0, owrite_req | oread_req}, 64'd0);
    chk("early_ack", {63'd0, op0_ack | op1_ack}, 64'd0);
    tick;
    chk("ack_p0", {63'd0, op0_ack}, {63'd0, !port});
    chk("ack_p1", {63'd0, op1_ack}, {63'd0, port});
    if (sb_q.size() == 0) chk("sb_empty", 64'd1, 64'd0);
    else begin
      e = sb_q.pop_front();
      chk("sb_data", e.port ? op1_rdata : op0_data, e.data);
    end
    chk("p0_data", op0_data, m0);
    chk("p1_rdata", op1_rdata, m1);
    if (drop) begin
      if (port) ip1_req = 1'b0;
      else ip0_req = 1'b0;
    end
    tick;
    chk("ack_pulse", {63'd0, op0_ack | op1_ack}, 64'd0);
  endtask
  initial begin
    #2;
    chk("rst_wreq", {63'd0, owrite_req}, 64'd0);
    chk("rst_rreq", {63'd0, oread_req}, 64'd0);
    chk("rst_busy", {63'd0, obusy}, 64'd0);
    chk("rst_acks", {62'd0, op0_ack, op1_ack}, 64'd0);
    chk("rst_data", op0_data | op1_rdata | owrite_data, 64'd0);
    tick;
    tick;
    ireset_n = 1'b1;
    tick;
    // port 0 read
    ip0_address = 22'h00010;
    ip0_req = 1'b1;
    tick;
    serve(1'b0, 1'b0, 22'h00010, 64'd0, 64'hDEADBEEF_CAFEF00D, 0, 1'b1);
    // port 1 write
    ip1_we = 1'b1;
    ip1_address = 22'h3FFFFF;
    ip1_wdata = 64'h0123456789ABCDEF;
    ip1_req = 1'b1;
    tick;
    serve(1'b1, 1'b1, 22'h3FFFFF, 64'h0123456789ABCDEF, 64'd0, 0, 1'b1);
    // contention: both held, strict alternation
    ip0_address = 22'h000A0;
    ip1_address = 22'h000B1;
    ip1_we = 1'b0;
    ip0_req = 1'b1;
    ip1_req = 1'b1;
    for (int i = 0; i < 4; i++)
      serve(i[0], 1'b0, i[0] ? 22'h000B1 : 22'h000A0, 64'd0, 64'h1000 + 64'(i), 0, 1'b0);
    ip0_req = 1'b0;
    ip1_req = 1'b0;
    serve(1'b0, 1'b0, 22'h000A0, 64'd0, 64'h2000, 0, 1'b1);
    tick;
    // ack withheld for controller init
    ip1_we = 1'b1;
    ip1_address = 22'h012345;
    ip1_wdata = 64'hFEED_0000_BEEF_1111;
    ip1_req = 1'b1;
    tick;
    serve(1'b1, 1'b1, 22'h012345, 64'hFEED_0000_BEEF_1111, 64'd0, 300, 1'b1);
    repeat (3) begin
      tick;
      chk("single_ack", {63'd0, op0_ack | op1_ack}, 64'd0);
    end
    // asynchronous reset mid-transaction
    ip1_address = 22'h000777;
    ip1_req = 1'b1;
    tick;
    tick;
    chk("pre_rst_wreq", {63'd0, owrite_req}, 64'd1);
    #3;
    ireset_n = 1'b0;
    #1;
    m0 = '0;
    m1 = '0;
    chk("arst_wreq", {63'd0, owrite_req}, 64'd0);
    chk("arst_rreq", {63'd0, oread_req}, 64'd0);
    chk("arst_busy", {63'd0, obusy}, 64'd0);
    chk("arst_acks", {62'd0, op0_ack, op1_ack}, 64'd0);
    chk("arst_data", op0_data | op1_rdata, 64'd0);
    ip1_req = 1'b0;
    tick;
    ireset_n = 1'b1;
    tick;
    ip0_address = 22'h00020;
    ip0_req = 1'b1;
    tick;
    serve(1'b0, 1'b0, 22'h00020, 64'd0, 64'h0BAD_F00D_1234_5678, 0, 1'b1);
    // stray acks
    iread_ack = 1'b1;
    iread_data = 64'hFFFF_0000_FFFF_0000;
    tick;
    iread_ack = 1'b0;
    tick;
    tick;
    chk("stray_r_ack", {62'd0, op0_ack, op1_ack}, 64'd0);
    chk("stray_r_busy", {63'd0, obusy}, 64'd0);
    chk("stray_r_d0", op0_data, m0);
    chk("stray_r_d1", op1_rdata, m1);
    ip0_address = 22'h00030;
    ip0_req = 1'b1;
    tick;
    iwrite_ack = 1'b1;
    tick;
    iwrite_ack = 1'b0;
    tick;
    chk("stray_w_rreq", {63'd0, oread_req}, 64'd1);
    chk("stray_w_ack", {62'd0, op0_ack, op1_ack}, 64'd0);
    chk("stray_w_d0", op0_data, m0);
    serve(1'b0, 1'b0, 22'h00030, 64'd0, 64'h7777_8888_9999_AAAA, 0, 1'b1);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
